// File: rtl/uart_tx_controller_if.sv
// Byte handshake and serializer hookup for the UART TX frame sequencer.
// master: system side plus serializer; slave: the frame sequencer.
interface uart_tx_controller_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Data_Valid;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  ser_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  TX_OUT;
  logic                  busy;
  logic                  frame_err;

  modport master (
    output Data_Valid, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    input  ser_en, TX_OUT, busy, frame_err
  );

  modport slave (
    input  Data_Valid, P_DATA, PAR_EN, PAR_TYP, ser_data, ser_done,
    output ser_en, TX_OUT, busy, frame_err
  );
endinterface

// File: rtl/uart_tx_controller.sv
// UART TX frame sequencer: start, DATA_WIDTH serializer bits, optional
// parity, STOP_BITS stop bits. One CLK per line bit. STOP_BITS is 1 or 2.
module uart_tx_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_tx_controller_if.slave   bus
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int SW = $clog2(STOP_BITS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]         stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bit_q;
  logic                  frame_err_q;
  logic                  accept;
  logic                  set_err;
  logic                  last_bit;

  // The serializer owns the data bits on the line; the latched byte and
  // parity type are kept only as a record of the frame in flight.
  logic unused_latched;
  assign unused_latched = ^{data_q, par_typ_q};

  assign last_bit = (bit_cnt_q == CW'(DATA_WIDTH - 1));

  // State, counters and per-frame configuration registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      data_q      <= '1;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
      par_bit_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      if (accept) begin
        data_q    <= bus.P_DATA;
        par_en_q  <= bus.PAR_EN;
        par_typ_q <= bus.PAR_TYP;
        par_bit_q <= (^bus.P_DATA) ^ bus.PAR_TYP;
      end
      if (set_err) frame_err_q <= 1'b1;
    end
  end

  // Next-state sequencing; watchdog ends DATA after DATA_WIDTH cycles even
  // without ser_done, flagging the frame but still finishing it cleanly.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    accept     = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        bit_cnt_d = '0;
        state_d   = DATA;
      end
      DATA: begin
        bit_cnt_d = bit_cnt_q + CW'(1);
        if (bus.ser_done || last_bit) begin
          set_err    = !bus.ser_done;
          stop_cnt_d = '0;
          state_d    = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        stop_cnt_d = '0;
        state_d    = STOP;
      end
      STOP: begin
        if (stop_cnt_q == SW'(STOP_BITS - 1)) begin
          stop_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + SW'(1);
        end
      end
      default: begin
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // Line outputs decoded from the registered state only.
  always_comb begin
    bus.TX_OUT = 1'b1;
    bus.ser_en = 1'b0;
    bus.busy   = 1'b0;
    case (state_q)
      START: begin
        bus.TX_OUT = 1'b0;
        bus.ser_en = 1'b1;
        bus.busy   = 1'b1;
      end
      DATA: begin
        bus.TX_OUT = bus.ser_data;
        bus.ser_en = 1'b1;
        bus.busy   = 1'b1;
      end
      PARITY: begin
        bus.TX_OUT = par_bit_q;
        bus.busy   = 1'b1;
      end
      STOP: begin
        bus.busy = 1'b1;
      end
      default: begin
        bus.TX_OUT = 1'b1;
      end
    endcase
  end

  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_tx_controller.sv
// Scoreboard bench for uart_tx_controller: directed frames push expected
// per-cycle line values; a negedge monitor pops and compares while busy.
module tb_uart_tx_controller;

  typedef struct packed {
    logic tx;
    logic en;
    logic err;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t q0[$];
  exp_t q1[$];
  logic [1:0] sticky;
  logic no_done;

  uart_tx_controller_if #(.DATA_WIDTH(8)) bus0 ();
  uart_tx_controller_if #(.DATA_WIDTH(8)) bus1 ();

  uart_tx_controller #(.DATA_WIDTH(8), .STOP_BITS(1)) dut0 (
    .CLK(clk), .RST(rst), .bus(bus0)
  );
  uart_tx_controller #(.DATA_WIDTH(8), .STOP_BITS(2)) dut1 (
    .CLK(clk), .RST(rst), .bus(bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Serializer models: load on accepted request, count enabled cycles.
  logic [3:0] cnt0, cnt1;
  logic [7:0] sb0, sb1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0; cnt1 <= '0; sb0 <= '1; sb1 <= '1;
    end else begin
      cnt0 <= bus0.ser_en ? cnt0 + 4'd1 : 4'd0;
      cnt1 <= bus1.ser_en ? cnt1 + 4'd1 : 4'd0;
      if (bus0.Data_Valid && !bus0.busy) sb0 <= bus0.P_DATA;
      if (bus1.Data_Valid && !bus1.busy) sb1 <= bus1.P_DATA;
    end
  end

  assign bus0.ser_data = (cnt0 >= 4'd1 && cnt0 <= 4'd8) ? sb0[cnt0 - 4'd1] : 1'b1;
  assign bus1.ser_data = (cnt1 >= 4'd1 && cnt1 <= 4'd8) ? sb1[cnt1 - 4'd1] : 1'b1;
  assign bus0.ser_done = !no_done && (cnt0 == 4'd8);
  assign bus1.ser_done = (cnt1 == 4'd8);

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int k, input logic busy, input logic tx,
                     input logic en, input logic err);
    exp_t e;
    logic got;
    got = 1'b0;
    e   = '0;
    if (busy) begin
      if (k == 0 && q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
      if (k == 1 && q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL dut%0d unexpected busy: got 1 expected 0 at %0t", k, $time);
      end else begin
        chk($sformatf("dut%0d frame TX_OUT", k), tx, e.tx);
        chk($sformatf("dut%0d frame ser_en", k), en, e.en);
        chk($sformatf("dut%0d frame frame_err", k), err, e.err);
      end
    end else begin
      chk($sformatf("dut%0d idle TX_OUT", k), tx, 1'b1);
      chk($sformatf("dut%0d idle ser_en", k), en, 1'b0);
      chk($sformatf("dut%0d idle frame_err", k), err, sticky[k]);
    end
  endtask

  // Monitor: compare every cycle away from the active edge.
  always @(negedge clk) begin
    mon(0, bus0.busy, bus0.TX_OUT, bus0.ser_en, bus0.frame_err);
    mon(1, bus1.busy, bus1.TX_OUT, bus1.ser_en, bus1.frame_err);
  end

  // Expected line string: character i is the line level in frame cycle i.
  task automatic push_frame(input int k, input string s, input int n_en,
                            input int err_from);
    exp_t e;
    for (int i = 0; i < s.len(); i++) begin
      e.tx  = (s[i] == "1");
      e.en  = (i < n_en);
      e.err = sticky[k] || (err_from >= 0 && i >= err_from);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic pen,
                      input logic ptyp, input int hold);
    @(negedge clk);
    if (k == 0) begin
      bus0.Data_Valid = 1'b1; bus0.P_DATA = d; bus0.PAR_EN = pen; bus0.PAR_TYP = ptyp;
    end else begin
      bus1.Data_Valid = 1'b1; bus1.P_DATA = d; bus1.PAR_EN = pen; bus1.PAR_TYP = ptyp;
    end
    repeat (1 + hold) @(posedge clk);
    @(negedge clk);
    bus0.Data_Valid = 1'b0;
    bus1.Data_Valid = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #2;
      if (k == 0 && q0.size() == 0 && !bus0.busy) return;
      if (k == 1 && q1.size() == 0 && !bus1.busy) return;
    end
    checks++;
    errors++;
    $display("FAIL dut%0d frame completion timeout: got busy expected idle", k);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sticky = 2'b00;
    no_done = 1'b0;
    rst = 1'b1;
    bus0.Data_Valid = 1'b0; bus0.P_DATA = '0; bus0.PAR_EN = 1'b0; bus0.PAR_TYP = 1'b0;
    bus1.Data_Valid = 1'b0; bus1.P_DATA = '0; bus1.PAR_EN = 1'b0; bus1.PAR_TYP = 1'b0;

    // Request during reset must be ignored.
    repeat (2) @(negedge clk);
    bus0.Data_Valid = 1'b1; bus0.P_DATA = 8'h3C;
    @(negedge clk);
    bus0.Data_Valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // 0xA5 even parity.
    push_frame(0, "01010010101", 9, -1);
    send(0, 8'hA5, 1'b1, 1'b0, 0);
    wait_idle(0);

    // 0xA5 odd parity.
    push_frame(0, "01010010111", 9, -1);
    send(0, 8'hA5, 1'b1, 1'b1, 0);
    wait_idle(0);

    // No parity slot.
    push_frame(0, "0101001011", 9, -1);
    send(0, 8'hA5, 1'b0, 1'b0, 0);
    wait_idle(0);

    // Two stop bits.
    push_frame(1, "010100101011", 9, -1);
    send(1, 8'hA5, 1'b1, 1'b0, 0);
    wait_idle(1);

    // Mid-frame request with different byte/config is dropped.
    push_frame(0, "01010010101", 9, -1);
    send(0, 8'hA5, 1'b1, 1'b0, 0);
    repeat (3) @(negedge clk);
    bus0.Data_Valid = 1'b1; bus0.P_DATA = 8'h3C; bus0.PAR_EN = 1'b0; bus0.PAR_TYP = 1'b1;
    @(negedge clk);
    bus0.Data_Valid = 1'b0;
    wait_idle(0);

    // Data_Valid held high: two frames separated by one idle cycle.
    push_frame(0, "0101001011", 9, -1);
    push_frame(0, "0101001011", 9, -1);
    send(0, 8'hA5, 1'b0, 1'b0, 11);
    wait_idle(0);

    // Asynchronous reset during DATA bit 4, then a clean frame.
    push_frame(0, "01010010101", 9, -1);
    send(0, 8'hA5, 1'b1, 1'b0, 0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async reset TX_OUT", bus0.TX_OUT, 1'b1);
    chk("async reset busy", bus0.busy, 1'b0);
    chk("async reset ser_en", bus0.ser_en, 1'b0);
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    push_frame(0, "01010010101", 9, -1);
    send(0, 8'hA5, 1'b1, 1'b0, 0);
    wait_idle(0);

    // Serializer never reports done: watchdog ends DATA after 8 cycles.
    no_done = 1'b1;
    push_frame(0, "01111000001", 9, 9);
    send(0, 8'h0F, 1'b1, 1'b0, 0);
    sticky[0] = 1'b1;
    wait_idle(0);
    no_done = 1'b0;
    repeat (3) @(negedge clk);
    push_frame(0, "01010010101", 9, -1);
    send(0, 8'hA5, 1'b1, 1'b0, 0);
    wait_idle(0);

    // Only reset clears the sticky error.
    rst = 1'b1;
    sticky[0] = 1'b0;
    #1;
    chk("reset clears frame_err", bus0.frame_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    chk("dut0 scoreboard drained", (q0.size() == 0), 1'b1);
    chk("dut1 scoreboard drained", (q1.size() == 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
